// File: rtl/spatial_bundler_stream_if.sv
// rtl/spatial_bundler_stream_if.sv - beat-in / hypervector-out handshake bundle for the spatial bundler
interface spatial_bundler_stream_if #(
    parameter int DIMENSION     = 1000,
    parameter int CHANNEL_WIDTH = 7,
    parameter int NUM_CHANNELS  = 4
);
    localparam int CNT_WIDTH = $clog2(NUM_CHANNELS + 1);

    logic                     Clear_SI;
    logic                     InValid_SI;
    logic                     InReady_SO;
    logic                     InLast_SI;
    logic [DIMENSION-1:0]     HypervectorIn_DI;
    logic [CHANNEL_WIDTH-1:0] FeatureIn_DI;
    logic [DIMENSION-1:0]     TieBreak_DI;
    logic                     OutValid_SO;
    logic                     OutReady_SI;
    logic [DIMENSION-1:0]     HypervectorOut_DO;
    logic [CNT_WIDTH-1:0]     BeatCount_DO;

    // Upstream sequencer / downstream temporal encoder side.
    modport master (
        output Clear_SI, InValid_SI, InLast_SI, HypervectorIn_DI, FeatureIn_DI,
               TieBreak_DI, OutReady_SI,
        input  InReady_SO, OutValid_SO, HypervectorOut_DO, BeatCount_DO
    );

    // Bundler side.
    modport slave (
        input  Clear_SI, InValid_SI, InLast_SI, HypervectorIn_DI, FeatureIn_DI,
               TieBreak_DI, OutReady_SI,
        output InReady_SO, OutValid_SO, HypervectorOut_DO, BeatCount_DO
    );
endinterface

// File: rtl/spatial_bundler_stream.sv
// rtl/spatial_bundler_stream.sv - feature-weighted bundling of channel hypervectors into one spatial hypervector per frame
module spatial_bundler_stream #(
    parameter int DIMENSION     = 1000,
    parameter int CHANNEL_WIDTH = 7,
    parameter int NUM_CHANNELS  = 4,
    parameter int ACC_WIDTH     = CHANNEL_WIDTH + $clog2(NUM_CHANNELS) + 1,
    parameter bit SATURATE      = 1'b0
) (
    input logic                    Clk_CI,
    input logic                    Reset_RBI,
    spatial_bundler_stream_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(NUM_CHANNELS + 1);

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_OUTPUT = 1'b1
    } state_e;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef logic signed [ACC_WIDTH:0]   sum_t;

    localparam sum_t ACC_MAX = sum_t'((2 ** (ACC_WIDTH - 1)) - 1);
    localparam sum_t ACC_MIN = sum_t'(-(2 ** (ACC_WIDTH - 1)));

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   first_q, first_d;
    acc_t                   acc_q [DIMENSION];
    acc_t                   acc_d [DIMENSION];
    logic [DIMENSION-1:0]   hv_out_q, hv_out_d;
    logic [CNT_WIDTH-1:0]   beats_q, beats_d;

    acc_t                   acc_new [DIMENSION];
    logic [DIMENSION-1:0]   hv_new;
    logic                   in_ready;
    logic                   out_valid;
    logic                   beat_fire;
    logic                   frame_end;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    // The sum is one bit wider than the accumulator, so overflow is visible before folding.
    function automatic acc_t fold(input sum_t s);
        acc_t r;
        r = s[ACC_WIDTH-1:0];
        if (SATURATE) begin
            if (s > ACC_MAX) begin
                r = ACC_MAX[ACC_WIDTH-1:0];
            end else if (s < ACC_MIN) begin
                r = ACC_MIN[ACC_WIDTH-1:0];
            end
        end
        return r;
    endfunction

    always_comb begin
        sum_t feat;
        sum_t base;
        sum_t delta;
        sum_t total;
        hv_new = '0;
        feat   = {{(ACC_WIDTH + 1 - CHANNEL_WIDTH){1'b0}}, bus.FeatureIn_DI};
        for (int i = 0; i < DIMENSION; i++) begin
            // The first beat overwrites, so stale sums never need an explicit clear.
            base       = first_q ? '0 : {acc_q[i][ACC_WIDTH-1], acc_q[i]};
            delta      = bus.HypervectorIn_DI[i] ? -feat : feat;
            total      = base + delta;
            acc_new[i] = fold(total);
            hv_new[i]  = (acc_new[i] == '0) ? bus.TieBreak_DI[i] : acc_new[i][ACC_WIDTH-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        acc_d     = acc_q;
        hv_out_d  = hv_out_q;
        beats_d   = beats_q;
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_OUTPUT);
        beat_fire = in_ready && bus.InValid_SI;
        cnt_inc   = cnt_q + 1'b1;
        frame_end = bus.InLast_SI || (cnt_inc == CNT_WIDTH'(NUM_CHANNELS));

        if (bus.Clear_SI) begin
            state_d = ST_ACCUM;
            cnt_d   = '0;
            first_d = 1'b1;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (beat_fire) begin
                        acc_d = acc_new;
                        if (frame_end) begin
                            state_d  = ST_OUTPUT;
                            cnt_d    = '0;
                            first_d  = 1'b1;
                            beats_d  = cnt_inc;
                            hv_out_d = hv_new;
                        end else begin
                            cnt_d   = cnt_inc;
                            first_d = 1'b0;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (bus.OutReady_SI) begin
                        state_d = ST_ACCUM;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_q  <= ST_ACCUM;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            hv_out_q <= '0;
            beats_q  <= '0;
            for (int i = 0; i < DIMENSION; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            hv_out_q <= hv_out_d;
            beats_q  <= beats_d;
            for (int i = 0; i < DIMENSION; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign bus.InReady_SO        = in_ready;
    assign bus.OutValid_SO       = out_valid;
    assign bus.HypervectorOut_DO = hv_out_q;
    assign bus.BeatCount_DO      = beats_q;
endmodule

// File: doc/spatial_bundler_stream.md
Name: spatial_bundler_stream

Overview:
- Streaming, parametrised HDC spatial encoder stage: bundles per-channel hypervectors, each weighted by its channel feature, into one binary spatial hypervector per frame.
- Sits between the item-memory/channel sequencer and the temporal encoder.
- Owns frame sequencing internally: channel counter, first-beat detection, early frame termination, saturating arithmetic, deterministic tie-break.
- Uses valid/ready handshakes on input and output.

Parameters:
DIMENSION, 1000, hypervector length in bits
CHANNEL_WIDTH, 7, unsigned feature width
NUM_CHANNELS, 4, maximum beats per frame
ACC_WIDTH, CHANNEL_WIDTH+$clog2(NUM_CHANNELS)+1, signed accumulator width per element
SATURATE, 0, 1 = clamp accumulators at signed limits, 0 = two's-complement wrap

Ports:
Clk_CI  in  1  clock
Reset_RBI  in  1  asynchronous active-low reset
Clear_SI  in  1  synchronous frame abort
InValid_SI  in  1  input beat valid
InReady_SO  out  1  input beat accepted when high with InValid_SI
InLast_SI  in  1  beat is last of frame
HypervectorIn_DI  in  DIMENSION  channel hypervector
FeatureIn_DI  in  CHANNEL_WIDTH  unsigned channel feature
TieBreak_DI  in  DIMENSION  bit used where accumulator equals zero
OutValid_SO  out  1  spatial hypervector valid
OutReady_SI  in  1  downstream accepts output
HypervectorOut_DO  out  DIMENSION  bundled spatial hypervector
BeatCount_DO  out  $clog2(NUM_CHANNELS+1)  beats in the last completed frame

Behaviour:
- Reset (Reset_RBI low, asynchronous): state ACCUM; accumulators 0; beat counter 0; first-beat flag 1; InReady_SO 1; OutValid_SO 0; HypervectorOut_DO 0; BeatCount_DO 0.
- FSM has two states.
  - ACCUM: InReady_SO=1, OutValid_SO=0.
  - OUTPUT: InReady_SO=0, OutValid_SO=1.
- Beat acceptance (ACCUM, InValid_SI=1): for each element i, d = HypervectorIn_DI[i] ? -Feature : +Feature, with Feature zero-extended to ACC_WIDTH.
  - First beat of frame: Acc[i] = d.
  - Later beats: Acc[i] = Acc[i] + d.
  - Beat counter increments on every accepted beat.
- SATURATE=1: a result above 2^(ACC_WIDTH-1)-1 clamps to that maximum; a result below -2^(ACC_WIDTH-1) clamps to that minimum. SATURATE=0: wraps.
- Frame end: the accepted beat has InLast_SI=1, or the beat counter reaches NUM_CHANNELS.
  - The final beat's contribution is included.
  - On the next edge the FSM enters OUTPUT.
  - HypervectorOut_DO[i] is registered from the final Acc: 1 if Acc<0, 0 if Acc>0, TieBreak_DI[i] (sampled on the final-beat edge) if Acc==0.
  - BeatCount_DO is registered with the frame's beat count.
  - Beat counter returns to 0 and first-beat flag is set.
- Latency: OutValid_SO rises 1 cycle after the final beat's accepting edge.
- OUTPUT: HypervectorOut_DO and BeatCount_DO are held stable until OutValid_SO & OutReady_SI.
  - On that edge: OutValid_SO falls, state returns to ACCUM, and InReady_SO rises the following cycle.
  - Input is never accepted in the same cycle as an output handshake.
  - HypervectorOut_DO keeps its last value after the handshake.
- Clear_SI (any state): next edge forces ACCUM, beat counter 0, first-beat flag 1, OutValid_SO 0.
  - Any in-progress or pending frame is discarded.
  - Clear_SI has priority over a simultaneous beat or output handshake; a beat presented that cycle is dropped.
- InValid_SI=0 in ACCUM: accumulators, counter and flag hold.
- Frame of exactly one beat is legal: output is sign(±Feature) per element.
- Feature 0 on every beat: all accumulators 0; output equals TieBreak_DI.
- Asynchronous reset asserted mid-frame or mid-output returns all state to reset values immediately.

Test Plan:
- Setup for all scenarios: DIMENSION=8, CHANNEL_WIDTH=4, NUM_CHANNELS=4, SATURATE=0, OutReady_SI=1.
- Full frame: 4 beats with HV=8'hF0 and features 3,2,1,1 (no InLast) -> OutValid_SO high 1 cycle after beat 4; HypervectorOut_DO=8'hF0; BeatCount_DO=4.
- Early end with tie: beats (HV=8'hFF, F=5) then (HV=8'h00, F=5, InLast=1), TieBreak_DI=8'hA5 -> HypervectorOut_DO=8'hA5, BeatCount_DO=2.
- Backpressure: OutReady_SI=0 for 10 cycles after a frame -> OutValid_SO and HypervectorOut_DO stable, InReady_SO=0 throughout; the beat accepted after release starts a fresh frame (no carry-over).
- Saturation: ACC_WIDTH=5, SATURATE=1, 4 beats HV=8'hFF, F=15 -> all Acc clamp at -16; output 8'hFF. With SATURATE=0 the same stimulus wraps to Acc=4, output 8'h00.
- Clear mid-frame: 2 beats accepted, Clear_SI pulsed together with a third valid beat -> no output produced; the next 4-beat frame from the first scenario yields 8'hF0, BeatCount_DO=4.
- Async reset: drop Reset_RBI low mid-OUTPUT, between clock edges -> OutValid_SO=0 and HypervectorOut_DO=0 immediately, InReady_SO=1 after release.
